store_narrow_unit: RTL and testbench
====================================

// Module: store_narrow_unit
// PURPOSE
//  Store-side counterpart of the immediate/load widening path. Accepts one 32-bit
//  register store request (sb/sh/sw) from the MEM stage. Narrows it into 1, 2 or 4
//  byte-wide write beats on an 8-bit data-memory port, each beat acknowledged by the memory.
//  Rejects misaligned or reserved-size requests with an error pulse.
// PARAMETERS
//  ADDR_W  32  byte-address width of addr_i / mem_addr_o
// PORTS
//  clk_i        in   1       clock; all logic on rising edge
//  rst_i        in   1       synchronous reset, active-low
//  req_valid_i  in   1       store request valid
//  req_ready_o  out  1       unit idle, may accept request
//  addr_i       in   ADDR_W  store byte address
//  data_i       in   32      register data; sized field is data_i[8*N-1:0]
//  size_i       in   2       00=byte 01=half 10=word 11=reserved
//  mem_we_o     out  1       write beat valid, held until mem_ack_i
//  mem_addr_o   out  ADDR_W  beat byte address
//  mem_data_o   out  8       beat byte
//  mem_ack_i    in   1       memory accepted current beat
//  done_o       out  1       1-cycle pulse: all beats written
//  err_o        out  1       1-cycle pulse: request rejected, no beats issued
// BEHAVIOUR
//  - Reset (rst_i==0 at edge): state=IDLE; req_ready_o=1; mem_we_o=0;
//    mem_addr_o=0; mem_data_o=0; done_o=0; err_o=0; beat index=0.
//  - States: IDLE, WRITE, DONE, ERR.
//  - IDLE: req_ready_o=1. On req_valid_i: register addr/data/size.
//    If size==11, or size==01 && addr[0], or size==10 && addr[1:0]!=0 -> ERR; else -> WRITE, idx=0.
//  - N = 1/2/4 beats for byte/half/word.
//  - WRITE: mem_we_o=1, mem_addr_o=base+idx (mod 2^ADDR_W), mem_data_o=byte sel(idx).
//    Outputs stable while mem_ack_i=0. On mem_ack_i: idx++ (next beat on next cycle).
//    Ack of beat N-1 -> DONE.
//  - DONE: done_o=1, mem_we_o=0, req_ready_o=0; next cycle -> IDLE.
//  - ERR: err_o=1, mem_we_o never asserted for this request; next cycle -> IDLE.
//  - req_ready_o=0 in WRITE/DONE/ERR. req_valid_i there is ignored, not queued.
//  - Latency with ack every cycle: accept at T, beats T+1..T+N, done_o at T+N+1,
//    req_ready_o=1 again at T+N+2. Error: err_o at T+1, ready at T+2.
//  - mem_ack_i outside WRITE is ignored. addr/data/size are sampled only at accept;
//    later changes have no effect.
//  - Reset mid-WRITE: returns to IDLE next edge, mem_we_o drops.
//    Beats already acked are not undone; done_o is not pulsed.
//  - done_o and err_o are never high together; never two requests in flight.
// CONFIGURATION
//  STORE_BIG_ENDIAN_EN
//    undefined: sel(idx) = data[8*idx+7 : 8*idx] (little-endian, LSB at lowest address).
//    defined:   sel(idx) = data[8*(N-1-idx)+7 : 8*(N-1-idx)] (MS byte of field at lowest addr).
//  Addresses and beat order are identical in both builds; only the lane selection differs.
// TESTING
//  1. sw addr=0x100 data=0x11223344, ack every cycle -> beats (0x100,44),(0x101,33),
//     (0x102,22),(0x103,11); done_o at T+5.
//  2. sh addr=0x202 data=0xAAAABEEF, ack after 2 wait cycles per beat -> (0x202,EF) held 3 cycles,
//     then (0x203,BE); done_o once.
//  3. sh addr=0x201, sw addr=0x102, size=11 -> err_o pulse each, mem_we_o stays 0, ready after 2 cycles.
//  4. sb addr=0xFFFFFFFF data=0x5A with req_valid_i held high through DONE
//     -> exactly one beat (0xFFFFFFFF,5A), one accept.
//  5. rst_i=0 after beat 1 of a sw -> IDLE next edge, mem_we_o=0, done_o=0; new sb completes normally.
//  6. STORE_BIG_ENDIAN_EN build, case 1 stimulus -> bytes 11,22,33,44 at 0x100..0x103.

Source files
------------

// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
//   Store-side narrowing unit. Accepts one 32-bit store request (sb/sh/sw)
//   from the MEM stage. Breaks it into 1, 2 or 4 byte-wide write beats on an
//   8-bit data-memory port. The memory acknowledges each beat. Misaligned or
//   reserved-size requests are rejected with a one-cycle error pulse, and no
//   beat is issued for them.
//
//   Build option:
//     STORE_BIG_ENDIAN_EN  defined   -> the most significant byte of the sized
//                                       field goes to the lowest address.
//                          undefined -> little-endian lane order (default).
//     Beat addresses and beat order are the same in both builds.
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        synchronous reset, active-low
//     req_valid_i  store request valid
//     req_ready_o  unit idle, a request may be accepted
//     addr_i       store byte address (ADDR_W)
//     data_i       register data; sized field is data_i[8*N-1:0]
//     size_i       00=byte 01=half 10=word 11=reserved
//     mem_we_o     write beat valid, held until mem_ack_i
//     mem_addr_o   beat byte address (ADDR_W)
//     mem_data_o   beat byte
//     mem_ack_i    memory accepted the current beat
//     done_o       one-cycle pulse: all beats written
//     err_o        one-cycle pulse: request rejected
// -----------------------------------------------------------------------------
module store_narrow_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    input  logic [1:0]        size_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic              mem_ack_i,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

`ifdef STORE_BIG_ENDIAN_EN
    localparam bit BIG_ENDIAN = 1'b1;
`else
    localparam bit BIG_ENDIAN = 1'b0;
`endif

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Request captured at accept; later input changes have no effect.
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  last;   // index of the final beat (N-1)
    } req_t;

    state_t           state;
    req_t             req_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;

    // Index of the last beat for a given size: byte->0, half->1, word->3.
    function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] size);
        case (size)
            SIZE_BYTE: last_idx = IDX_W'(0);
            SIZE_HALF: last_idx = IDX_W'(1);
            default:   last_idx = IDX_W'(3);
        endcase
    endfunction

    // Reject the reserved size and any access that is not naturally aligned.
    function automatic logic reject(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: reject = 1'b0;
            SIZE_HALF: reject = lo[0];
            SIZE_WORD: reject = (lo != 2'b00);
            default:   reject = 1'b1;
        endcase
    endfunction

    // Byte lane written on beat i; big-endian mirrors the lane inside the field.
    function automatic logic [BYTE_W-1:0] beat_byte(input logic [DATA_W-1:0] data,
                                                    input logic [IDX_W-1:0]  last,
                                                    input logic [IDX_W-1:0]  i);
        logic [IDX_W-1:0] lane;
        lane = BIG_ENDIAN ? IDX_W'(last - i) : i;
        case (lane)
            2'd0:    beat_byte = data[7:0];
            2'd1:    beat_byte = data[15:8];
            2'd2:    beat_byte = data[23:16];
            default: beat_byte = data[31:24];
        endcase
    endfunction

    assign idx_nxt = IDX_W'(idx + IDX_W'(1));

    // Control FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            req_q       <= '0;
            idx         <= '0;
            req_ready_o <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        req_q.base  <= addr_i;
                        req_q.data  <= data_i;
                        req_q.last  <= last_idx(size_i);
                        idx         <= '0;
                        req_ready_o <= 1'b0;
                        if (reject(size_i, addr_i[1:0])) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end else begin
                            // First beat presented directly from the inputs.
                            state      <= S_WRITE;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= addr_i;
                            mem_data_o <= beat_byte(data_i, last_idx(size_i), IDX_W'(0));
                        end
                    end
                end

                S_WRITE: begin
                    if (mem_ack_i) begin
                        if (idx == req_q.last) begin
                            state    <= S_DONE;
                            mem_we_o <= 1'b0;
                            done_o   <= 1'b1;
                        end else begin
                            idx        <= idx_nxt;
                            mem_addr_o <= req_q.base + ADDR_W'(idx_nxt);
                            mem_data_o <= beat_byte(req_q.data, req_q.last, idx_nxt);
                        end
                    end
                end

                S_DONE, S_ERR: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                end

                default: begin
                    state       <= S_IDLE;
                    req_ready_o <= 1'b1;
                    mem_we_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  size_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_ack_i;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef STORE_BIG_ENDIAN_EN
    localparam logic [7:0] W_EXP [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    localparam logic [7:0] H_EXP [2] = '{8'hBE, 8'hEF};
`else
    localparam logic [7:0] W_EXP [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [7:0] H_EXP [2] = '{8'hEF, 8'hBE};
`endif

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .size_i      (size_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full beat view: {we, addr, data, done, err, ready}.
    function automatic logic [43:0] beat_view();
        return {mem_we_o, mem_addr_o, mem_data_o, done_o, err_o, req_ready_o};
    endfunction

    // Control view: {we, done, err, ready}.
    function automatic logic [3:0] ctl_view();
        return {mem_we_o, done_o, err_o, req_ready_o};
    endfunction

    task automatic test_reset();
        logic [43:0] exp;
        rst_i = 1'b0; req_valid_i = 1'b1; mem_ack_i = 1'b1;
        addr_i = 32'h100; data_i = 32'h11223344; size_i = 2'b10;
        step(); step();
        exp = {1'b0, 32'h0, 8'h0, 3'b001};
        if (beat_view() !== exp) begin
            $display("FAIL reset: got %h want %h", beat_view(), exp);
            n_bad++;
        end
        n_cmp++;
        req_valid_i = 1'b0; mem_ack_i = 1'b0; rst_i = 1'b1;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL reset_release: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_word();
        logic [43:0] exp;
        if (req_ready_o !== 1'b1) begin
            $display("FAIL word_ready: got %b want 1", req_ready_o);
            n_bad++;
        end
        n_cmp++;
        req_valid_i = 1'b1; addr_i = 32'h100; data_i = 32'h11223344; size_i = 2'b10;
        step();
        req_valid_i = 1'b0; data_i = 32'hDEADBEEF; addr_i = 32'h0; mem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, 32'h100 + 32'(i), W_EXP[i], 3'b000};
            if (beat_view() !== exp) begin
                $display("FAIL word_beat%0d: got %h want %h", i, beat_view(), exp);
                n_bad++;
            end
            n_cmp++;
            step();
        end
        if (ctl_view() !== 4'b0100) begin
            $display("FAIL word_done: got %b want 0100", ctl_view());
            n_bad++;
        end
        n_cmp++;
        mem_ack_i = 1'b0;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL word_idle: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_half_wait();
        logic [43:0] exp;
        req_valid_i = 1'b1; addr_i = 32'h202; data_i = 32'hAAAABEEF; size_i = 2'b01;
        mem_ack_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int w = 0; w < 3; w++) begin
                mem_ack_i = (w == 2);
                exp = {1'b1, 32'h202 + 32'(b), H_EXP[b], 3'b000};
                if (beat_view() !== exp) begin
                    $display("FAIL half_beat%0d_wait%0d: got %h want %h", b, w, beat_view(), exp);
                    n_bad++;
                end
                n_cmp++;
                step();
            end
        end
        mem_ack_i = 1'b0;
        if (ctl_view() !== 4'b0100) begin
            $display("FAIL half_done: got %b want 0100", ctl_view());
            n_bad++;
        end
        n_cmp++;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL half_single_done: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs = '{32'h201, 32'h102, 32'h100};
        sizes = '{2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 3; k++) begin
            req_valid_i = 1'b1; addr_i = addrs[k]; data_i = 32'hCAFEF00D; size_i = sizes[k];
            mem_ack_i = 1'b1;
            step();
            req_valid_i = 1'b0;
            if (ctl_view() !== 4'b0010) begin
                $display("FAIL err%0d_pulse: got %b want 0010", k, ctl_view());
                n_bad++;
            end
            n_cmp++;
            step();
            if (ctl_view() !== 4'b0001) begin
                $display("FAIL err%0d_ready: got %b want 0001", k, ctl_view());
                n_bad++;
            end
            n_cmp++;
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_hold_valid();
        logic [43:0] exp;
        req_valid_i = 1'b1; addr_i = 32'hFFFFFFFF; data_i = 32'h1234565A; size_i = 2'b00;
        mem_ack_i = 1'b1;
        step();
        exp = {1'b1, 32'hFFFFFFFF, 8'h5A, 3'b000};
        if (beat_view() !== exp) begin
            $display("FAIL hold_beat: got %h want %h", beat_view(), exp);
            n_bad++;
        end
        n_cmp++;
        step();
        if (ctl_view() !== 4'b0100) begin
            $display("FAIL hold_done: got %b want 0100", ctl_view());
            n_bad++;
        end
        n_cmp++;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL hold_ready: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
        req_valid_i = 1'b0;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL hold_no_reaccept: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [43:0] exp;
        req_valid_i = 1'b1; addr_i = 32'h100; data_i = 32'h11223344; size_i = 2'b10;
        mem_ack_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        exp = {1'b1, 32'h101, W_EXP[1], 3'b000};
        if (beat_view() !== exp) begin
            $display("FAIL rmid_beat1: got %h want %h", beat_view(), exp);
            n_bad++;
        end
        n_cmp++;
        rst_i = 1'b0; mem_ack_i = 1'b0;
        step();
        exp = {1'b0, 32'h0, 8'h0, 3'b001};
        if (beat_view() !== exp) begin
            $display("FAIL rmid_reset: got %h want %h", beat_view(), exp);
            n_bad++;
        end
        n_cmp++;
        rst_i = 1'b1;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL rmid_no_done: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
        req_valid_i = 1'b1; addr_i = 32'h300; data_i = 32'h00000077; size_i = 2'b00;
        mem_ack_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        exp = {1'b1, 32'h300, 8'h77, 3'b000};
        if (beat_view() !== exp) begin
            $display("FAIL rmid_sb_beat: got %h want %h", beat_view(), exp);
            n_bad++;
        end
        n_cmp++;
        step();
        if (ctl_view() !== 4'b0100) begin
            $display("FAIL rmid_sb_done: got %b want 0100", ctl_view());
            n_bad++;
        end
        n_cmp++;
        mem_ack_i = 1'b0;
        step();
        if (ctl_view() !== 4'b0001) begin
            $display("FAIL rmid_sb_idle: got %b want 0001", ctl_view());
            n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_ack_idle();
        req_valid_i = 1'b0; mem_ack_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            if (ctl_view() !== 4'b0001) begin
                $display("FAIL ack_idle%0d: got %b want 0001", c, ctl_view());
                n_bad++;
            end
            n_cmp++;
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; req_valid_i = 1'b0; mem_ack_i = 1'b0;
        addr_i = '0; data_i = '0; size_i = '0;
        test_reset();
        test_word();
        test_half_wait();
        test_errors();
        test_hold_valid();
        test_reset_mid();
        test_ack_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
